// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_flex FIFO family.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Occupancy runs 0..DEPTH inclusive, hence DEPTH+1 distinct values.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// DEPTH x DWIDTH storage array: synchronous write port, asynchronous read port.
module fifo_flex_mem #(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard/FWFT read, level flags and sticky errors.
// Optional peak-occupancy tracker enabled by defining FIFO_FLEX_PEAK_EN.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 8,
  parameter int FWFT     = MODE_STD,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          wr,
  input  logic [DWIDTH-1:0]             dataIn,
  input  logic                          rd,
  output logic [DWIDTH-1:0]             dataOut,
  output logic                          rd_valid,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow
`ifdef FIFO_FLEX_PEAK_EN
  ,
  output logic [count_width(DEPTH)-1:0] peak
`endif
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] mem_rdata;
  logic              rd_acc, wr_acc;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO can still take a write when a read frees a slot in the same cycle.
  assign rd_acc = en && !clr && rd && !empty;
  assign wr_acc = en && !clr && wr && (!full || rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = 1'b0;
    dout_d      = dout_q;
    if (en) begin
      if (clr) begin
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        count_d     = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
          rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
          dout_d     = mem_rdata;
          rd_valid_d = 1'b1;
        end
        if (wr_acc && !rd_acc) begin
          count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
          count_d = count_q - CW'(1);
        end
        if (wr && !wr_acc) begin
          overflow_d = 1'b1;
        end
        if (rd && empty) begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      dout_q      <= dout_d;
    end
  end

  fifo_flex_mem #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(dataIn),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word is always presented; rd acts as the pop acknowledge.
      assign dataOut  = mem_rdata;
      assign rd_valid = !empty;
    end else begin : g_std
      assign dataOut  = dout_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

`ifdef FIFO_FLEX_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (en) begin
      if (clr) begin
        peak_d = '0;
      end else if (count_d > peak_q) begin
        peak_d = count_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed self-checking bench for fifo_flex: a DEPTH=5 standard-read instance and a DEPTH=5 FWFT instance.
// The peak checks are compiled in when FIFO_FLEX_PEAK_EN is defined.
module tb_fifo_flex;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Standard-read instance (a_*)
  logic       a_en, a_clr, a_wr, a_rd;
  logic [7:0] a_din, a_dout;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [2:0] a_cnt;
`ifdef FIFO_FLEX_PEAK_EN
  logic [2:0] a_peak;
  logic [2:0] b_peak;
`endif

  // FWFT instance (b_*)
  logic       b_en, b_clr, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_cnt;

  fifo_flex #(.DWIDTH(8), .DEPTH(5), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .en(a_en), .clr(a_clr), .wr(a_wr), .dataIn(a_din),
    .rd(a_rd), .dataOut(a_dout), .rd_valid(a_rv), .count(a_cnt), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_udf)
`ifdef FIFO_FLEX_PEAK_EN
    , .peak(a_peak)
`endif
  );

  fifo_flex #(.DWIDTH(8), .DEPTH(5), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .en(b_en), .clr(b_clr), .wr(b_wr), .dataIn(b_din),
    .rd(b_rd), .dataOut(b_dout), .rd_valid(b_rv), .count(b_cnt), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_udf)
`ifdef FIFO_FLEX_PEAK_EN
    , .peak(b_peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_en = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_en = 1'b1; a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = 8'h00;
    b_en = 1'b1; b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = 8'h00;
    #23;
    chk("rst_count", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_dout", a_dout, 8'h00);
    chk("rst_rv", a_rv, 0);
    chk("rst_flags", {a_ovf, a_udf}, 2'b00);
    tick();
    rst_n = 1'b1;

    // Fill 0x11..0x55
    for (int i = 1; i <= 5; i++) begin
      a_wr = 1'b1; a_din = 8'(i * 8'h11);
      tick();
      $display("write %0h -> count=%0d af=%0b full=%0b", a_din, a_cnt, a_af, a_full);
      if (i == 3) chk("af_at3", a_af, 0);
      if (i == 4) chk("af_at4", a_af, 1);
    end
    chk("fill_count", a_cnt, 5);
    chk("fill_full", a_full, 1);
    a_din = 8'h66;
    tick();
    $display("write 66 while full -> count=%0d ovf=%0b", a_cnt, a_ovf);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_cnt, 5);
    a_idle();

    // Drain in order
    for (int i = 1; i <= 5; i++) begin
      a_rd = 1'b1;
      tick();
      $display("read -> dout=%0h rv=%0b count=%0d", a_dout, a_rv, a_cnt);
      chk("drain_dout", a_dout, 32'(i * 8'h11));
      chk("drain_rv", a_rv, 1);
    end
    a_idle();
    tick();
    chk("drain_rv_drop", a_rv, 0);
    chk("drain_hold", a_dout, 8'h55);
    chk("drain_empty", a_empty, 1);

    // Underflow on empty
    a_rd = 1'b1;
    tick();
    $display("read empty -> udf=%0b rv=%0b dout=%0h", a_udf, a_rv, a_dout);
    chk("udf_set", a_udf, 1);
    chk("udf_rv", a_rv, 0);
    chk("udf_dout", a_dout, 8'h55);
    a_wr = 1'b1; a_din = 8'hA5;
    tick();
    $display("rd+wr empty A5 -> count=%0d udf=%0b", a_cnt, a_udf);
    chk("rdwr_empty_count", a_cnt, 1);
    chk("rdwr_empty_rv", a_rv, 0);
    a_idle(); a_rd = 1'b1;
    tick();
    $display("read after wrap -> dout=%0h", a_dout);
    chk("wrap_dout", a_dout, 8'hA5);
    chk("wrap_empty", a_empty, 1);
    a_idle(); a_clr = 1'b1;
    tick();
    chk("clr_udf", a_udf, 0);
    chk("clr_ovf", a_ovf, 0);

    // Simultaneous read and write while full
    a_idle();
    for (int i = 1; i <= 5; i++) begin
      a_wr = 1'b1; a_din = 8'(i);
      tick();
    end
    a_rd = 1'b1; a_din = 8'h77;
    tick();
    $display("rd+wr full 77 -> count=%0d ovf=%0b dout=%0h", a_cnt, a_ovf, a_dout);
    chk("rdwr_full_count", a_cnt, 5);
    chk("rdwr_full_ovf", a_ovf, 0);
    chk("rdwr_full_dout", a_dout, 8'h01);
    a_wr = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      tick();
      $display("read -> dout=%0h", a_dout);
      chk("rdwr_drain", a_dout, (i == 6) ? 32'h77 : 32'(i));
    end
    a_idle();
    tick();
    chk("rdwr_empty", a_empty, 1);

    // clr after underflow and partial fill
    a_rd = 1'b1;
    tick();
    a_idle();
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_din = 8'(8'hC0 + i);
      tick();
    end
    chk("pre_clr_count", a_cnt, 3);
    a_clr = 1'b1;
    tick();
    $display("clr -> count=%0d empty=%0b udf=%0b", a_cnt, a_empty, a_udf);
    chk("clr_count", a_cnt, 0);
    chk("clr_empty", a_empty, 1);
    chk("clr_flags", {a_ovf, a_udf}, 2'b00);

    // en low freezes state
    a_idle(); a_en = 1'b0; a_wr = 1'b1; a_din = 8'h99;
    tick();
    chk("en_low_count", a_cnt, 0);
    a_idle();

`ifdef FIFO_FLEX_PEAK_EN
    for (int i = 0; i < 4; i++) begin
      a_wr = 1'b1; a_din = 8'(i);
      tick();
    end
    a_idle();
    for (int i = 0; i < 3; i++) begin
      a_rd = 1'b1;
      tick();
    end
    a_idle();
    $display("peak after fill 4 drain to 1 -> peak=%0d count=%0d", a_peak, a_cnt);
    chk("peak_4", a_peak, 4);
    chk("peak_cnt1", a_cnt, 1);
    a_clr = 1'b1;
    tick();
    a_idle();
    chk("peak_clr", a_peak, 0);
`endif

    // Asynchronous reset mid-burst
    a_wr = 1'b1; a_din = 8'hE1;
    tick();
    a_din = 8'hE2;
    tick();
    a_wr = 1'b0; a_rd = 1'b1;
    tick();
    chk("pre_rst_rv", a_rv, 1);
    a_rd = 1'b0; a_wr = 1'b1; a_din = 8'hE3;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset -> count=%0d rv=%0b dout=%0h empty=%0b", a_cnt, a_rv, a_dout, a_empty);
    chk("arst_count", a_cnt, 0);
    chk("arst_rv", a_rv, 0);
    chk("arst_dout", a_dout, 8'h00);
    chk("arst_empty", a_empty, 1);
    a_idle();
    tick();
    rst_n = 1'b1;

    // FWFT instance
    b_wr = 1'b1; b_din = 8'h3C;
    tick();
    b_wr = 1'b0;
    $display("fwft write 3C -> dout=%0h rv=%0b", b_dout, b_rv);
    chk("fwft_dout", b_dout, 8'h3C);
    chk("fwft_rv", b_rv, 1);
    b_wr = 1'b1; b_din = 8'h4D;
    tick();
    b_wr = 1'b0; b_rd = 1'b1;
    chk("fwft_head_hold", b_dout, 8'h3C);
    tick();
    $display("fwft pop -> dout=%0h count=%0d", b_dout, b_cnt);
    chk("fwft_next", b_dout, 8'h4D);
    tick();
    b_rd = 1'b0;
    $display("fwft pop last -> empty=%0b rv=%0b", b_empty, b_rv);
    chk("fwft_empty", b_empty, 1);
    chk("fwft_rv_low", b_rv, 0);
    chk("fwft_no_udf", b_udf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
